reg_window_ctrl: RTL

Window controller for the 8×16-bit, 4-window register file (2-bit window select, stride 2, 2-register overlap). Tracks the current window pointer on call/return and spills or fills overlapped registers to a memory stack when the physical file overflows or underflows. Sits between the decode/control unit and the register file, overriding register-file ports during spill/fill and stalling the processor via `busy`.

---
 rtl/reg_window_pkg.sv | 37 +++
 rtl/rf_port_mux.sv | 69 ++++++
 rtl/reg_window_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_window_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_window_pkg
// Description : Shared types and constants for the register-window
//               controller (window geometry, FSM state encoding, helpers).
// Revision    : 1.0 - initial release
// ============================================================================
package reg_window_pkg;

    // Register-file window geometry
    localparam int NUM_WINDOWS   = 4;
    localparam int WINDOW_STRIDE = 2;
    localparam int MAX_RESIDENT  = 3;

    // Window index type, wide enough for NUM_WINDOWS (wraps mod 4)
    typedef logic [$clog2(NUM_WINDOWS)-1:0] win_t;

    // Controller sequencing states
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        SP_RD0 = 4'd1,
        SP_WR0 = 4'd2,
        SP_RD1 = 4'd3,
        SP_WR1 = 4'd4,
        FL_RD0 = 4'd5,
        FL_WR0 = 4'd6,
        FL_RD1 = 4'd7,
        FL_WR1 = 4'd8
    } state_e;

    // Oldest resident window: cwp - res + 1, wrapping mod NUM_WINDOWS
    function automatic win_t oldest_window(input win_t cwp, input win_t res);
        return cwp - res + win_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_port_mux.sv
`default_nettype none
// ============================================================================
// Module      : rf_port_mux
// Description : Combinational override of the register-file ports. Passes
//               processor requests through when idle, and hands the ports
//               to the spill/fill sequencer otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_port_mux
    import reg_window_pkg::*;
(
    input  state_e      state,
    input  win_t        cwp,
    input  win_t        oldest,
    input  logic [1:0]  cpuReadReg1,
    input  logic [1:0]  cpuWriteReg,
    input  logic [15:0] cpuWriteData,
    input  logic        cpuWriteEn,
    input  logic [15:0] fillData,
    output win_t        rfWindow,
    output logic [1:0]  rfReadReg1,
    output logic [1:0]  rfWriteReg,
    output logic [15:0] rfWriteData,
    output logic        rfWriteEn
);

    // Select who owns the register-file ports for the current state
    always_comb begin
        rfWindow    = cwp;
        rfReadReg1  = cpuReadReg1;
        rfWriteReg  = cpuWriteReg;
        rfWriteData = cpuWriteData;
        rfWriteEn   = cpuWriteEn;
        case (state)
            // Spill reads the oldest window; read index held across the
            // write state so the synchronous read data stays stable.
            SP_RD0, SP_WR0: begin
                rfWindow   = oldest;
                rfReadReg1 = 2'd0;
                rfWriteEn  = 1'b0;
            end
            SP_RD1, SP_WR1: begin
                rfWindow   = oldest;
                rfReadReg1 = 2'd1;
                rfWriteEn  = 1'b0;
            end
            // Fill restores into the window below the current one
            FL_RD0, FL_RD1: begin
                rfWindow  = cwp - win_t'(1);
                rfWriteEn = 1'b0;
            end
            FL_WR0: begin
                rfWindow    = cwp - win_t'(1);
                rfWriteReg  = 2'd1;
                rfWriteData = fillData;
                rfWriteEn   = 1'b1;
            end
            FL_WR1: begin
                rfWindow    = cwp - win_t'(1);
                rfWriteReg  = 2'd0;
                rfWriteData = fillData;
                rfWriteEn   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/reg_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_window_ctrl
// Description : Register-window controller. Tracks the current window
//               pointer across call/return and spills/fills the two
//               overlapped registers to a memory stack on overflow or
//               underflow, stalling the processor via busy meanwhile.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_window_ctrl
    import reg_window_pkg::*;
#(
    parameter logic [15:0] STACK_BASE = 16'h00F0,
    parameter int          MAX_SAVED  = 8
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        call,
    input  logic        ret,
    input  logic [1:0]  cpuReadReg1,
    input  logic [1:0]  cpuWriteReg,
    input  logic [15:0] cpuWriteData,
    input  logic        cpuWriteEn,
    input  logic [15:0] rfReadData1,
    output logic [1:0]  rfWindow,
    output logic [1:0]  rfReadReg1,
    output logic [1:0]  rfWriteReg,
    output logic [15:0] rfWriteData,
    output logic        rfWriteEn,
    output logic        memReq,
    output logic        memWe,
    output logic [15:0] memAddr,
    output logic [15:0] memWData,
    input  logic [15:0] memRData,
    input  logic        memAck,
    output logic        busy,
    output logic        err
);

    localparam int          SAVED_W = $clog2(MAX_SAVED + 1);
    // Each spill/fill moves the overlapped registers: one stride's worth
    localparam logic [15:0] SP_STEP = 16'(WINDOW_STRIDE);

    state_e             state_q,    state_d;
    win_t               cwp_q,      cwp_d;
    win_t               res_q,      res_d;
    logic [SAVED_W-1:0] saved_q,    saved_d;
    logic [15:0]        sp_q,       sp_d;
    logic [15:0]        data_q,     data_d;
    logic               err_q,      err_d;
    logic               busy_q,     busy_d;
    logic               mem_req_q,  mem_req_d;
    logic               mem_we_q,   mem_we_d;
    logic [15:0]        mem_addr_q, mem_addr_d;

    win_t               oldest;

    assign oldest = oldest_window(cwp_q, res_q);

    // Sequencer next state, window bookkeeping and sticky error
    always_comb begin
        state_d = state_q;
        cwp_d   = cwp_q;
        res_d   = res_q;
        saved_d = saved_q;
        sp_d    = sp_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (call && ret) begin
                    err_d = 1'b1;
                end else if (call) begin
                    if (res_q < win_t'(MAX_RESIDENT)) begin
                        cwp_d = cwp_q + win_t'(1);
                        res_d = res_q + win_t'(1);
                    end else if (saved_q < SAVED_W'(MAX_SAVED)) begin
                        state_d = SP_RD0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (ret) begin
                    if (res_q > win_t'(1)) begin
                        cwp_d = cwp_q - win_t'(1);
                        res_d = res_q - win_t'(1);
                    end else if (saved_q != '0) begin
                        state_d = FL_RD0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SP_RD0: state_d = SP_WR0;
            SP_WR0: begin
                data_d = rfReadData1;
                if (memAck) state_d = SP_RD1;
            end
            SP_RD1: state_d = SP_WR1;
            SP_WR1: begin
                data_d = rfReadData1;
                if (memAck) begin
                    state_d = IDLE;
                    sp_d    = sp_q + SP_STEP;
                    saved_d = saved_q + SAVED_W'(1);
                    cwp_d   = cwp_q + win_t'(1);
                end
            end
            FL_RD0: begin
                if (memAck) begin
                    data_d  = memRData;
                    state_d = FL_WR0;
                end
            end
            FL_WR0: state_d = FL_RD1;
            FL_RD1: begin
                if (memAck) begin
                    data_d  = memRData;
                    state_d = FL_WR1;
                end
            end
            FL_WR1: begin
                state_d = IDLE;
                sp_d    = sp_q - SP_STEP;
                saved_d = saved_q - SAVED_W'(1);
                cwp_d   = cwp_q - win_t'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes are decoded from the next state so they come out of flops
    always_comb begin
        busy_d     = (state_d != IDLE);
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = '0;
        case (state_d)
            SP_WR0: begin
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b1;
                mem_addr_d = sp_q;
            end
            SP_WR1: begin
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b1;
                mem_addr_d = sp_q + 16'd1;
            end
            FL_RD0: begin
                mem_req_d  = 1'b1;
                mem_addr_d = sp_q - 16'd1;
            end
            FL_RD1: begin
                mem_req_d  = 1'b1;
                mem_addr_d = sp_q - 16'd2;
            end
            default: ;
        endcase
    end

    // State and output registers; async reset aborts any sequence in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cwp_q      <= '0;
            res_q      <= win_t'(1);
            saved_q    <= '0;
            sp_q       <= STACK_BASE;
            data_q     <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cwp_q      <= cwp_d;
            res_q      <= res_d;
            saved_q    <= saved_d;
            sp_q       <= sp_d;
            data_q     <= data_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign busy    = busy_q;
    assign err     = err_q;
    assign memReq  = mem_req_q;
    assign memWe   = mem_we_q;
    assign memAddr = mem_addr_q;
    // Read index is held through the write state, so the RF data is stable
    assign memWData = ((state_q == SP_WR0) || (state_q == SP_WR1)) ? rfReadData1 : 16'h0000;

    rf_port_mux u_rf_port_mux (
        .state        (state_q),
        .cwp          (cwp_q),
        .oldest       (oldest),
        .cpuReadReg1  (cpuReadReg1),
        .cpuWriteReg  (cpuWriteReg),
        .cpuWriteData (cpuWriteData),
        .cpuWriteEn   (cpuWriteEn),
        .fillData     (data_q),
        .rfWindow     (rfWindow),
        .rfReadReg1   (rfReadReg1),
        .rfWriteReg   (rfWriteReg),
        .rfWriteData  (rfWriteData),
        .rfWriteEn    (rfWriteEn)
    );

endmodule
`default_nettype wire
